// File: rtl/uart_frame_fifo_bridge_pkg.sv
// Shared types and defaults for the UART frame-to-FIFO bridge.
// Optional build macro: CRC_PARALLEL_EN (single-cycle CRC update).
package uart_frame_fifo_bridge_pkg;

    localparam logic [7:0] DEF_CRC_POLY = 8'h07;
    localparam logic [7:0] DEF_CRC_INIT = 8'h00;
    localparam int         ERR_CNT_W    = 8;
    localparam int         RX_ERR_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WRITE,
        ST_CRC,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/uart_frame_fifo_bridge_if.sv
// Receiver handshake and FIFO write bus of the frame bridge.
// Optional build macro: CRC_PARALLEL_EN (no effect on this file).
interface uart_frame_fifo_bridge_if
    import uart_frame_fifo_bridge_pkg::*;
#(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;
    logic [RX_ERR_W-1:0] rx_err;
    logic                rx_ack;
    logic                fifo_busy;
    logic [DATA_W-1:0]   fifo_data_out;
    logic                fifo_we;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_err,
        output fifo_busy,
        input  rx_ack,
        input  fifo_data_out,
        input  fifo_we
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_err,
        input  fifo_busy,
        output rx_ack,
        output fifo_data_out,
        output fifo_we
    );

endinterface

// File: rtl/uart_frame_fifo_bridge_crc_engine.sv
// CRC register with init/load/step controls, MSB-first.
// Optional build macro: CRC_PARALLEL_EN (all bit-steps in one cycle).
module uart_frame_fifo_bridge_crc_engine #(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
    parameter logic [CRC_W-1:0] CRC_INIT = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o,
    output logic              last_o
);

    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    function automatic logic [CRC_W-1:0] crc_bit(
        input logic [CRC_W-1:0] c,
        input logic             b
    );
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return (c << 1) ^ (fb ? CRC_POLY : '0);
    endfunction

`ifdef CRC_PARALLEL_EN

    function automatic logic [CRC_W-1:0] crc_word(
        input logic [CRC_W-1:0]  c,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            r = crc_bit(r, d[i]);
        end
        return r;
    endfunction

    // Next CRC: whole word folded in a single step cycle
    always_comb begin
        crc_d = crc_q;
        sh_d  = sh_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (step_i) begin
            crc_d = crc_word(crc_q, sh_q);
        end
        if (load_i) begin
            sh_d = data_i;
        end
    end

    assign last_o = 1'b1;

    // CRC and word holding registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
            sh_q  <= '0;
        end else begin
            crc_q <= crc_d;
            sh_q  <= sh_d;
        end
    end

`else

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next CRC: one data bit per step, shifting the word out MSB first
    always_comb begin
        crc_d = crc_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (step_i && cnt_q != '0) begin
            crc_d = crc_bit(crc_q, sh_q[DATA_W-1]);
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = CNT_W'(DATA_W);
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

    // CRC, shift and bit-count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            crc_q <= crc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

`endif

    assign crc_o = crc_q;

endmodule

// File: rtl/uart_frame_fifo_bridge.sv
// UART word to FIFO bridge with framed CRC check and bad-frame count.
// Optional build macro: CRC_PARALLEL_EN (passed to the CRC engine).
module uart_frame_fifo_bridge
    import uart_frame_fifo_bridge_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] CRC_POLY  = CRC_W'(DEF_CRC_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT  = CRC_W'(DEF_CRC_INIT),
    parameter int               FRAME_LEN = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    uart_frame_fifo_bridge_if.slave  bus,
    output logic [CRC_W-1:0]         crc,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int IDX_W = $clog2(FRAME_LEN + 1);

    state_t               state_q;
    logic                 ack_q;
    logic                 we_q;
    logic                 done_q;
    logic                 ok_q;
    logic                 bad_q;
    logic [DATA_W-1:0]    word_q;
    logic [DATA_W-1:0]    dout_q;
    logic [RX_ERR_W-1:0]  err_q;
    logic [IDX_W-1:0]     idx_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 crc_init;
    logic                 crc_load;
    logic                 crc_step;
    logic                 crc_last;
    logic [CRC_W-1:0]     crc_val;
    logic                 last_word;
    logic                 frame_pass;

    // CRC engine controls follow the FSM state, gated by enable
    always_comb begin
        crc_init = enable && (state_q == ST_CHECK);
        crc_load = enable && (state_q == ST_WRITE) && !bus.fifo_busy;
        crc_step = enable && (state_q == ST_CRC);
    end

    uart_frame_fifo_bridge_crc_engine #(
        .DATA_W   (DATA_W),
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .clk_i  (clk),
        .rst_ni (reset),
        .init_i (crc_init),
        .load_i (crc_load),
        .step_i (crc_step),
        .data_i (word_q),
        .crc_o  (crc_val),
        .last_o (crc_last)
    );

    assign last_word  = (idx_q == IDX_W'(FRAME_LEN));
    assign frame_pass = !bad_q
                     && (crc_val == word_q[CRC_W-1:0])
                     && (err_q == '0);

    // Main FSM: accept, ack, write, CRC, and end-of-frame check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            word_q    <= '0;
            dout_q    <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else if (enable) begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        word_q  <= bus.rx_data;
                        err_q   <= bus.rx_err;
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!bus.rx_valid) begin
                        ack_q <= 1'b0;
                        if (last_word) begin
                            state_q <= ST_CHECK;
                        end else if (err_q != '0) begin
                            bad_q   <= 1'b1;
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!bus.fifo_busy) begin
                        dout_q  <= word_q;
                        we_q    <= 1'b1;
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (crc_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    ok_q   <= frame_pass;
                    done_q <= 1'b1;
                    if (!frame_pass && err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                    idx_q   <= '0;
                    bad_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A held pulse stays masked while frozen and shows again on resume
    assign bus.fifo_we       = we_q & enable;
    assign frame_done        = done_q & enable;
    assign bus.rx_ack        = ack_q;
    assign bus.fifo_data_out = dout_q;
    assign frame_ok          = ok_q;
    assign err_cnt           = err_cnt_q;
    assign crc               = crc_val;

endmodule

// File: tb/tb_uart_frame_fifo_bridge.sv
// Randomised bench for uart_frame_fifo_bridge with a frame-level model.
// Works for both builds (CRC_PARALLEL_EN defined or not).
module tb_uart_frame_fifo_bridge;

    localparam int DW = 8;
    localparam int FL = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] crc;
    logic       frame_done;
    logic       frame_ok;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_frame_fifo_bridge_if #(.DATA_W(DW)) bus ();

    uart_frame_fifo_bridge #(
        .DATA_W    (DW),
        .CRC_W     (8),
        .CRC_POLY  (8'h07),
        .CRC_INIT  (8'h00),
        .FRAME_LEN (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .crc        (crc),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_cnt    (err_cnt)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         errcnt_m = 0;
    bit         rnd_on   = 0;
    int         done_cnt = 0;
    logic       last_ok  = 1'b0;
    logic [7:0] run_crc;
    logic [7:0] fr_data[FL];
    logic [3:0] fr_err[FL];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte-wise CRC-8 (poly 0x07): xor the byte in, then divide 8 times
    function automatic logic [7:0] crc_ref(input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // FIFO scoreboard and frame-result capture
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1 && bus.fifo_we === 1'b1) begin
            if (exp_q.size() == 0)
                chk("fifo_spurious", exp_q.size(), 1);
            else
                chk("fifo_data", bus.fifo_data_out, exp_q.pop_front());
        end
        if (reset === 1'b1 && frame_done === 1'b1) begin
            done_cnt++;
            last_ok = frame_ok;
        end
    end

    // Random busy / enable disturbance
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) begin
            bus.fifo_busy = ($urandom_range(0, 3) == 0);
            enable        = ($urandom_range(0, 4) != 0);
        end
    end

    task automatic wait_ack(input logic v);
        int n = 0;
        @(negedge clk);
        while (bus.rx_ack !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ack !== v) chk("ack_timeout", bus.rx_ack, v);
    endtask

    task automatic send_word(input logic [7:0] d, input logic [3:0] e,
                             input int freeze);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        bus.rx_err   = e;
        wait_ack(1'b1);
        if (freeze > 0) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            for (int i = 0; i < freeze; i++) begin
                @(negedge clk);
                chk("frz_ack", bus.rx_ack, 1);
                chk("frz_we", bus.fifo_we, 0);
                chk("frz_done", frame_done, 0);
                chk("frz_crc", crc, run_crc);
            end
            @(posedge clk);
            #1;
            enable = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic do_frame(input bit good_cw, input logic [3:0] cw_err,
                            input bit chk_crc, input logic [8:0] crc_fix,
                            input int freeze_at, input int busy_at);
        logic [7:0] pre;
        logic [7:0] cw;
        bit         bad;
        bit         exp_ok;
        int         d0;
        int         n;
        pre = 8'h00;
        bad = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (fr_err[i] == 4'h0) pre = crc_ref(pre, fr_data[i]);
            else bad = 1'b1;
        end
        cw      = good_cw ? pre : (pre ^ 8'h5A);
        run_crc = 8'h00;
        for (int i = 0; i < FL; i++) begin
            if (fr_err[i] == 4'h0) exp_q.push_back(fr_data[i]);
            if (i == busy_at) begin
                @(posedge clk);
                #1;
                bus.fifo_busy = 1'b1;
            end
            send_word(fr_data[i], fr_err[i], (i == freeze_at) ? 10 : 0);
            if (i == busy_at) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk("busy_we", bus.fifo_we, 0);
                end
                @(posedge clk);
                #1;
                bus.fifo_busy = 1'b0;
                @(posedge clk);
                #1;
                chk("busy_we_after", bus.fifo_we, 1);
                chk("busy_data", bus.fifo_data_out, fr_data[i]);
            end
            if (fr_err[i] == 4'h0) run_crc = crc_ref(run_crc, fr_data[i]);
        end
        if (chk_crc) begin
            repeat (DW + 6) @(negedge clk);
            chk("crc_run", crc, crc_fix[8] ? crc_fix[7:0] : pre);
        end
        exp_ok = !bad && (cw == pre) && (cw_err == 4'h0);
        if (!exp_ok && errcnt_m < 255) errcnt_m++;
        d0 = done_cnt;
        send_word(cw, cw_err, 0);
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", done_cnt - d0, 1);
        chk("frame_ok", last_ok, exp_ok);
        chk("err_cnt", err_cnt, errcnt_m);
        chk("fifo_drained", exp_q.size(), 0);
        chk("crc_reinit", crc, 0);
    endtask

    task automatic rand_frame(input int err_odds);
        for (int i = 0; i < FL; i++) begin
            fr_data[i] = 8'($urandom);
            fr_err[i]  = (err_odds > 0 && $urandom_range(0, err_odds) == 0)
                       ? 4'($urandom_range(1, 15)) : 4'h0;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ack", bus.rx_ack, 0);
        chk("rst_we", bus.fifo_we, 0);
        chk("rst_dout", bus.fifo_data_out, 0);
        chk("rst_crc", crc, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_errcnt", err_cnt, 0);
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.rx_err    = '0;
        bus.fifo_busy = 1'b0;
        enable        = 1'b0;
        reset         = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;

        // "123456789" frame, check word 0xF4
        for (int i = 0; i < FL; i++) begin
            fr_data[i] = 8'h31 + 8'(i);
            fr_err[i]  = 4'h0;
        end
        do_frame(1'b1, 4'h0, 1'b1, 9'h1F4, -1, -1);

        // Wrong check word, then clean frame with a freeze mid-word
        rand_frame(0);
        do_frame(1'b0, 4'h0, 1'b1, 9'h000, -1, -1);
        rand_frame(0);
        do_frame(1'b1, 4'h0, 1'b1, 9'h000, 4, -1);

        // FIFO busy held across a payload word
        rand_frame(0);
        fr_data[2] = 8'hA5;
        do_frame(1'b1, 4'h0, 1'b1, 9'h000, -1, 2);

        // Receiver error on a payload word, and on the check word
        rand_frame(0);
        fr_err[3] = 4'h2;
        do_frame(1'b1, 4'h0, 1'b1, 9'h000, -1, -1);
        rand_frame(0);
        do_frame(1'b1, 4'h8, 1'b0, 9'h000, -1, -1);

        // Random frames under random busy and enable
        rnd_on = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rand_frame(12);
            do_frame($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 9) == 0)
                         ? 4'($urandom_range(1, 15)) : 4'h0,
                     1'b0, 9'h000, -1, -1);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        enable        = 1'b1;
        bus.fifo_busy = 1'b0;

        // Saturate the bad-frame counter
        for (int f = 0; f < 260; f++) begin
            for (int i = 0; i < FL; i++) begin
                fr_data[i] = 8'($urandom);
                fr_err[i]  = 4'h1;
            end
            do_frame(1'b1, 4'h0, 1'b0, 9'h000, -1, -1);
        end
        chk("err_sat", err_cnt, 255);

        // Reset during the CRC of a partial frame
        rand_frame(0);
        exp_q.push_back(fr_data[0]);
        exp_q.push_back(fr_data[1]);
        send_word(fr_data[0], 4'h0, 0);
        send_word(fr_data[1], 4'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        errcnt_m = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        rand_frame(0);
        do_frame(1'b1, 4'h0, 1'b1, 9'h000, -1, -1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
